lsu: RTL and testbench

- Per-thread load/store unit: the initiator end of the LSU <-> data-memory valid/ready request interface served by the data-memory arbiters.
- Accepts one decoded memory op from the warp pipeline, computes the word address and drives a held valid/address request until the arbiter grants it.
- For loads, captures the returned data after the fixed BRAM read latency, then reports completion to the pipeline.
- Instantiated THREADS_PER_WARP times for vector lanes and once for the scalar lane in each compute_core.

---
 rtl/lsu.sv | 160 ++++++++++++++++
 tb/tb_lsu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Per-thread load/store unit. Takes one decoded memory op, forms
//            the word address, holds a valid/address request until the data
//            memory arbiter grants it, waits out the fixed BRAM read latency
//            for loads, then reports completion to the warp pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
   parameter int ADDR_WIDTH      = 12,
   parameter int DATA_WIDTH      = 32,
   parameter int MEM_DEPTH_WORDS = 4096,
   parameter int READ_LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  is_load,
   input  logic                  is_store,
   input  logic [31:0]           base_addr,
   input  logic [31:0]           offset,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic                  ack,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  mem_read_valid,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   input  logic                  mem_read_ready,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  mem_write_valid,
   output logic [ADDR_WIDTH-1:0] mem_write_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic                  mem_write_ready
);

   // Counter only has to hold READ_LATENCY-1; keep at least one bit.
   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] C_CNT_INIT  = CNT_W'(READ_LATENCY - 1);
   localparam logic [31:0]      C_MEM_LIMIT = 32'(MEM_DEPTH_WORDS);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_REQUESTING = 2'd1;
   localparam logic [1:0] S_WAITING    = 2'd2;
   localparam logic [1:0] S_DONE       = 2'd3;

   logic [1:0]            state_q,   state_d;
   logic                  is_read_q, is_read_d;
   logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
   logic [DATA_WIDTH-1:0] ldata_q,   ldata_d;
   logic                  err_q,     err_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;

   logic [31:0] addr_sum;
   logic        out_of_range;

   // Effective address: 32-bit wrapping sum, range-checked before truncation.
   always_comb begin
      addr_sum     = base_addr + offset;
      out_of_range = (addr_sum >= C_MEM_LIMIT);
   end

   // Next-state logic for the single-outstanding-request sequencer.
   always_comb begin
      state_d   = state_q;
      is_read_d = is_read_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ldata_d   = ldata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((is_load && is_store) || out_of_range) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (!is_load && !is_store) begin
                  err_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  addr_d    = addr_sum[ADDR_WIDTH-1:0];
                  is_read_d = is_load;
                  if (is_store) begin
                     wdata_d = store_data;
                  end
                  state_d = S_REQUESTING;
               end
            end
         end
         S_REQUESTING: begin
            // Only the grant matching the pending direction is honoured.
            if (is_read_q && mem_read_ready) begin
               cnt_d   = C_CNT_INIT;
               state_d = S_WAITING;
            end else if (!is_read_q && mem_write_ready) begin
               err_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_WAITING: begin
            // Counter hits zero in the cycle the BRAM output is valid.
            if (cnt_q == '0) begin
               ldata_d = mem_read_data;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            if (ack) begin
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and operand registers; reset aborts any in-flight transaction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         is_read_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ldata_q   <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         is_read_q <= is_read_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ldata_q   <= ldata_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   // Outputs decode directly from registered state, so they are glitch-free
   // and drop to zero the moment reset asserts.
   always_comb begin
      busy              = (state_q == S_REQUESTING) || (state_q == S_WAITING);
      done              = (state_q == S_DONE);
      error             = err_q;
      load_data         = ldata_q;
      mem_read_valid    = (state_q == S_REQUESTING) && is_read_q;
      mem_write_valid   = (state_q == S_REQUESTING) && !is_read_q;
      mem_read_address  = addr_q;
      mem_write_address = addr_q;
      mem_write_data    = wdata_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu: directed scenarios plus randomized
//            ops checked against a transaction-level memory/result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

   localparam int          AW    = 12;
   localparam int          DW    = 32;
   localparam int          DEPTH = 4096;
   localparam int          LAT   = 2;
   localparam logic [31:0] LIMIT = 32'd4096;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start, is_load, is_store, ack;
   logic [31:0]   base_addr, offset;
   logic [DW-1:0] store_data;
   logic          busy, done, error;
   logic [DW-1:0] load_data;
   logic          mem_read_valid, mem_read_ready;
   logic [AW-1:0] mem_read_address;
   logic [DW-1:0] mem_read_data;
   logic          mem_write_valid, mem_write_ready;
   logic [AW-1:0] mem_write_address;
   logic [DW-1:0] mem_write_data;

   lsu #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load),
      .is_store(is_store), .base_addr(base_addr), .offset(offset),
      .store_data(store_data), .ack(ack), .busy(busy), .done(done),
      .error(error), .load_data(load_data),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far; stable when read at a falling edge.
   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   // Reference state: memory contents and the architecturally visible result.
   logic [31:0] mem_m [0:DEPTH-1];
   logic [31:0] ld_model;
   int          n_checks = 0;
   int          n_fail   = 0;

   // Pending read return scheduled by the arbiter/BRAM model.
   bit          rd_pending = 1'b0;
   int          rd_ret_edge = 0;
   logic [31:0] rd_val;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance to the next falling edge and present BRAM read data: the
   // requested word only in the cycle ending READ_LATENCY edges after grant.
   task automatic next_cycle();
      @(negedge clk);
      if (rd_pending && (edge_n + 1 == rd_ret_edge)) mem_read_data = rd_val;
      else                                          mem_read_data = $urandom;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"},   32'(busy), 0);
      check_eq({tag, "_done"},   32'(done), 0);
      check_eq({tag, "_error"},  32'(error), 0);
      check_eq({tag, "_ldata"},  load_data, 0);
      check_eq({tag, "_rvalid"}, 32'(mem_read_valid), 0);
      check_eq({tag, "_wvalid"}, 32'(mem_write_valid), 0);
      check_eq({tag, "_raddr"},  32'(mem_read_address), 0);
      check_eq({tag, "_waddr"},  32'(mem_write_address), 0);
      check_eq({tag, "_wdata"},  mem_write_data, 0);
   endtask

   // One full op from start to ack; entered and left at a falling edge with
   // the DUT idle. gdelay = cycles the grant is withheld, ackdelay = cycles
   // done is held before ack, stray = pulse start while busy and while done.
   task automatic run_op(input bit ld, input bit st, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] sdata,
                         input int gdelay, input int ackdelay, input bit stray);
      logic [31:0]   sum;
      bit            err, nop;
      logic [AW-1:0] a;
      int            acc_edge;
      int            guard;
      sum = base + off;
      err = (ld && st) || (sum >= LIMIT);
      nop = !err && !ld && !st;
      a   = sum[AW-1:0];
      acc_edge = 0;

      start = 1'b1; is_load = ld; is_store = st;
      base_addr = base; offset = off; store_data = sdata; ack = 1'b0;
      mem_read_ready = 1'($urandom); mem_write_ready = 1'($urandom);
      next_cycle();
      start = 1'b0;
      is_load = 1'($urandom); is_store = 1'($urandom);
      base_addr = $urandom; offset = $urandom; store_data = $urandom;
      mem_read_ready = 1'b0; mem_write_ready = 1'b0;

      if (!err && !nop) begin
         for (int t = 0; t <= gdelay; t++) begin
            start = 1'b0;
            check_eq("req_valid", 32'(ld ? mem_read_valid : mem_write_valid), 1);
            check_eq("req_other_valid", 32'(ld ? mem_write_valid : mem_read_valid), 0);
            check_eq("req_busy", 32'(busy), 1);
            check_eq("req_done", 32'(done), 0);
            check_eq("req_addr", 32'(ld ? mem_read_address : mem_write_address), 32'(a));
            if (st) check_eq("req_wdata", mem_write_data, sdata);
            if (stray && t == 1) begin
               start = 1'b1; base_addr = $urandom; is_load = 1'b1; is_store = 1'b0;
            end
            if (t == gdelay) begin
               if (ld) mem_read_ready = 1'b1; else mem_write_ready = 1'b1;
               acc_edge = edge_n + 1;
               if (ld) begin
                  rd_pending  = 1'b1;
                  rd_ret_edge = acc_edge + LAT;
                  rd_val      = mem_m[a];
               end
            end
            next_cycle();
         end
         start = 1'b0; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
         if (st) begin
            check_eq("wr_done_latency", 32'(edge_n), 32'(acc_edge));
            mem_m[a] = sdata;
         end else begin
            check_eq("rd_valid_drop", 32'(mem_read_valid), 0);
            guard = 0;
            while (!done && guard < 50) begin
               check_eq("wait_busy", 32'(busy), 1);
               check_eq("wait_rvalid", 32'(mem_read_valid), 0);
               mem_read_ready = 1'($urandom);
               mem_write_ready = 1'($urandom);
               next_cycle();
               guard++;
            end
            mem_read_ready = 1'b0; mem_write_ready = 1'b0;
            if (!done) check_eq("rd_done_timeout", 32'(done), 1);
            check_eq("rd_done_latency", 32'(edge_n), 32'(rd_ret_edge));
            rd_pending = 1'b0;
            ld_model   = rd_val;
         end
      end

      for (int k = 0; k <= ackdelay; k++) begin
         start = 1'b0;
         check_eq("done_flag", 32'(done), 1);
         check_eq("done_busy", 32'(busy), 0);
         check_eq("done_error", 32'(error), 32'(err));
         check_eq("done_ldata", load_data, ld_model);
         check_eq("done_rvalid", 32'(mem_read_valid), 0);
         check_eq("done_wvalid", 32'(mem_write_valid), 0);
         if (k == ackdelay) ack = 1'b1;
         else if (stray && k == 0) begin
            start = 1'b1; is_load = 1'b0; is_store = 1'b1; base_addr = 32'h10;
         end
         mem_read_ready = 1'($urandom); mem_write_ready = 1'($urandom);
         next_cycle();
      end
      ack = 1'b0; start = 1'b0; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      check_eq("idle_done", 32'(done), 0);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_error", 32'(error), 0);
      check_eq("idle_ldata", load_data, ld_model);
      check_eq("idle_rvalid", 32'(mem_read_valid), 0);
      check_eq("idle_wvalid", 32'(mem_write_valid), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ld, st;
      logic [31:0] b, o;
      int          kind;

      for (int i = 0; i < DEPTH; i++) mem_m[i] = $urandom;
      ld_model = '0;
      reset_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; ack = 1'b0;
      base_addr = '0; offset = '0; store_data = '0;
      mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
      next_cycle();
      next_cycle();
      check_reset_outputs("rst");
      reset_n = 1'b1;
      next_cycle();
      check_reset_outputs("post_rst");

      // Load 0x100+4 with grant after three valid cycles.
      mem_m[12'h104] = 32'hDEADBEEF;
      run_op(1'b1, 1'b0, 32'h100, 32'h4, 32'h0, 2, 0, 1'b0);
      check_eq("dir_load_value", load_data, 32'hDEADBEEF);

      // Store with negative offset, granted immediately, then read back.
      run_op(1'b0, 1'b1, 32'h20, 32'hFFFFFFFC, 32'h12345678, 0, 1, 1'b0);
      run_op(1'b1, 1'b0, 32'h1C, 32'h0, 32'h0, 1, 0, 1'b0);
      check_eq("dir_store_readback", load_data, 32'h12345678);

      // Rejected ops: out of range and both load and store.
      run_op(1'b1, 1'b0, 32'hFFF, 32'h1, 32'h0, 0, 1, 1'b0);
      run_op(1'b1, 1'b1, 32'h10, 32'h0, 32'h0, 0, 1, 1'b0);
      // Nop leaves load_data untouched.
      run_op(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0, 1, 1'b0);

      // Backpressure with stray start, then a long result hold.
      run_op(1'b1, 1'b0, 32'h200, 32'h8, 32'h0, 10, 5, 1'b1);
      run_op(1'b0, 1'b1, 32'h300, 32'h0, 32'hCAFEF00D, 10, 5, 1'b1);

      // Reset in WAITING, one cycle after the grant.
      start = 1'b1; is_load = 1'b1; is_store = 1'b0; base_addr = 32'h300; offset = 32'h0;
      next_cycle();
      start = 1'b0;
      check_eq("rstw_rvalid", 32'(mem_read_valid), 1);
      mem_read_ready = 1'b1;
      rd_pending = 1'b1; rd_ret_edge = edge_n + 1 + LAT; rd_val = mem_m[12'h300];
      next_cycle();
      mem_read_ready = 1'b0;
      check_eq("rstw_busy_before", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("rstw");
      rd_pending = 1'b0;
      ld_model = '0;
      next_cycle();
      reset_n = 1'b1;
      next_cycle();
      check_reset_outputs("rstw_rel");
      run_op(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 0, 0, 1'b0);
      check_eq("rstw_reload", load_data, 32'hCAFEF00D);

      // Randomized ops against the reference model.
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 9);
         ld = (kind <= 4) || (kind == 9);
         st = (kind >= 5 && kind <= 8) || (kind == 9);
         if (kind == 8 && ($urandom_range(0, 1) == 0)) begin ld = 1'b0; st = 1'b0; end
         b = $urandom_range(0, DEPTH + 200);
         case ($urandom_range(0, 3))
            0:       o = $urandom;
            1:       o = -32'($urandom_range(0, 64));
            default: o = 32'($urandom_range(0, 64));
         endcase
         run_op(ld, st, b, o, $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
